// File: rtl/mult_arb_if.sv
// Bundle of requester and shared-multiplier handshake signals for mult_arb.
// slave is the arbiter view; master is the requester/multiplier environment view.
interface mult_arb_if #(
   parameter int N = 16
);
   logic             req0;
   logic             req1;
   logic [N-1:0]     ain0;
   logic [N-1:0]     bin0;
   logic [N-1:0]     ain1;
   logic [N-1:0]     bin1;
   logic             ack0;
   logic             ack1;
   logic [2*N-1:0]   res;
   logic             err;
   logic             busy;
   logic             m_start;
   logic [N-1:0]     m_ain;
   logic [N-1:0]     m_bin;
   logic             m_done;
   logic [2*N-1:0]   m_yout;

   modport slave (
      input  req0, req1, ain0, bin0, ain1, bin1, m_done, m_yout,
      output ack0, ack1, res, err, busy, m_start, m_ain, m_bin
   );

   modport master (
      output req0, req1, ain0, bin0, ain1, bin1, m_done, m_yout,
      input  ack0, ack1, res, err, busy, m_start, m_ain, m_bin
   );
endinterface

// File: rtl/mult_arb.sv
// Round-robin arbiter sharing one shift-add multiplier between two requesters.
// Optional BUSY-state abort after TIMEOUT cycles is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arb #(
   parameter int N       = 16,
   parameter int TIMEOUT = 40
) (
   input logic       clk,
   input logic       resetb,
   mult_arb_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]     state;
   logic           last_grant;
   logic           grant;
   logic           pick;
   logic [2*N-1:0] res_q;
   logic [N-1:0]   ain_q;
   logic [N-1:0]   bin_q;
   logic           expired;

   // A tie goes to whoever was not granted last; otherwise the lone requester wins.
   always_comb begin
      pick = bus.req1;
      if (bus.req0 && bus.req1) begin
         pick = ~last_grant;
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] tcount;
   logic          err_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         tcount <= '0;
      end else if (state == START) begin
         tcount <= '0;
      end else if (state == BUSY && !bus.m_done) begin
         tcount <= tcount + CW'(1);
      end
   end

   assign expired = (state == BUSY) && !bus.m_done && (tcount == CW'(TIMEOUT - 1));
   assign bus.err = (state == RESP) && err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT != 0);
   assign expired        = 1'b0;
   assign bus.err        = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         res_q      <= '0;
         ain_q      <= '0;
         bin_q      <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.req0 || bus.req1) begin
                  grant      <= pick;
                  last_grant <= pick;
                  ain_q      <= pick ? bus.ain1 : bus.ain0;
                  bin_q      <= pick ? bus.bin1 : bus.bin0;
                  state      <= START;
               end
            end
            START: begin
               state <= BUSY;
            end
            BUSY: begin
               if (bus.m_done) begin
                  res_q <= bus.m_yout;
`ifdef MULT_ARB_TIMEOUT_EN
                  err_q <= 1'b0;
`endif
                  state <= RESP;
               end else if (expired) begin
                  res_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
                  err_q <= 1'b1;
`endif
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Strobes are decoded from the state so they can never outlive a reset.
   assign bus.ack0    = (state == RESP) && !grant;
   assign bus.ack1    = (state == RESP) && grant;
   assign bus.m_start = (state == START);
   assign bus.busy    = (state != IDLE);
   assign bus.res     = res_q;
   assign bus.m_ain   = ain_q;
   assign bus.m_bin   = bin_q;
endmodule
